// File: rtl/joystick_reader.sv
// PmodJSTK poller: every POLL_CYCLES clocks runs a 5-byte SPI mode-0 exchange,
// then publishes the X/Y readings and a player control code with a one-cycle strobe.
module joystick_reader #(
  parameter int CLK_DIV     = 50,
  parameter int SS_DELAY    = 1500,
  parameter int BYTE_GAP    = 1000,
  parameter int POLL_CYCLES = 1000000,
  parameter int LEFT_TH     = 384,
  parameter int RIGHT_TH    = 640
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Led,
  input  logic       MISO,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  output logic [9:0] X_pos,
  output logic [9:0] Y_pos,
  output logic [3:0] Joystick_data,
  output logic       Data_valid
);

  localparam int DLY_MAX = (SS_DELAY > BYTE_GAP) ? SS_DELAY : BYTE_GAP;
  localparam int POLL_W  = $clog2(POLL_CYCLES + 1);
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int DIV_W   = $clog2(CLK_DIV + 1);

  localparam logic [9:0] LEFT_V  = 10'(LEFT_TH);
  localparam logic [9:0] RIGHT_V = 10'(RIGHT_TH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [POLL_W-1:0] poll_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        byte_idx;
  logic [7:0]        rx_sr;
  logic [7:0]        cmd;
  logic [7:0]        x_lo;
  logic [1:0]        x_hi;
  logic [7:0]        y_lo;
  logic [1:0]        y_hi;

  logic              poll_wrap;
  logic              div_end;
  logic [2:0]        next_bit;
  logic [7:0]        tx_byte;
  logic [9:0]        x_new;
  logic [9:0]        y_new;
  logic [2:0]        dir;
  logic              fire;

  assign poll_wrap = (poll_cnt == POLL_W'(POLL_CYCLES - 1));
  assign div_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign next_bit  = bit_idx - 3'd1;
  assign tx_byte   = (byte_idx == 3'd0) ? cmd : 8'h00;

  // Byte 4 is still in the shift register on the edge that enters DONE.
  assign x_new = {x_hi, x_lo};
  assign y_new = {y_hi, y_lo};
  assign fire  = rx_sr[1] | rx_sr[0];

  always_comb begin
    dir = 3'd5;
    if (x_new < LEFT_V) begin
      dir = 3'd3;
    end else if (x_new > RIGHT_V) begin
      dir = 3'd7;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      dly_cnt       <= '0;
      div_cnt       <= '0;
      bit_idx       <= 3'd7;
      byte_idx      <= 3'd0;
      rx_sr         <= 8'h00;
      cmd           <= 8'h00;
      x_lo          <= 8'h00;
      x_hi          <= 2'b00;
      y_lo          <= 8'h00;
      y_hi          <= 2'b00;
      SS            <= 1'b1;
      SCLK          <= 1'b0;
      MOSI          <= 1'b0;
      X_pos         <= 10'd0;
      Y_pos         <= 10'd0;
      Joystick_data <= 4'd5;
      Data_valid    <= 1'b0;
    end else begin
      poll_cnt   <= poll_wrap ? '0 : poll_cnt + 1'b1;
      Data_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (poll_wrap) begin
            state   <= SETUP;
            SS      <= 1'b0;
            dly_cnt <= DLY_W'(SS_DELAY - 1);
            cmd     <= {6'b100000, Led};
          end
        end

        SETUP: begin
          if (dly_cnt == '0) begin
            state    <= SHIFT;
            byte_idx <= 3'd0;
            bit_idx  <= 3'd7;
            div_cnt  <= '0;
            SCLK     <= 1'b0;
            MOSI     <= cmd[7];
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end

        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (!SCLK) begin
              SCLK  <= 1'b1;
              rx_sr <= {rx_sr[6:0], MISO};
            end else begin
              SCLK <= 1'b0;
              if (bit_idx == 3'd0) begin
                MOSI <= 1'b0;
                if (byte_idx == 3'd4) begin
                  state         <= DONE;
                  SS            <= 1'b1;
                  X_pos         <= x_new;
                  Y_pos         <= y_new;
                  Joystick_data <= {fire, dir};
                  Data_valid    <= 1'b1;
                end else begin
                  case (byte_idx)
                    3'd0:    x_lo <= rx_sr;
                    3'd1:    x_hi <= rx_sr[1:0];
                    3'd2:    y_lo <= rx_sr;
                    default: y_hi <= rx_sr[1:0];
                  endcase
                  state   <= GAP;
                  dly_cnt <= DLY_W'(BYTE_GAP - 1);
                end
              end else begin
                bit_idx <= next_bit;
                MOSI    <= tx_byte[next_bit];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        GAP: begin
          if (dly_cnt == '0) begin
            state    <= SHIFT;
            byte_idx <= byte_idx + 3'd1;
            bit_idx  <= 3'd7;
            div_cnt  <= '0;
            // Only the command byte carries ones; every later byte is all zero.
            MOSI     <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt - 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joystick_reader.sv
// Bench for joystick_reader: SPI slave model, scoreboard of expected updates,
// per-window SCLK/MOSI timing checks and reset abort behaviour.
module tb_joystick_reader;

  localparam int CLK_DIV     = 2;
  localparam int SS_DELAY    = 4;
  localparam int BYTE_GAP    = 3;
  localparam int POLL_CYCLES = 200;
  localparam int NVEC        = 11;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Led;
  logic       MISO;
  logic       SS;
  logic       SCLK;
  logic       MOSI;
  logic [9:0] X_pos;
  logic [9:0] Y_pos;
  logic [3:0] Joystick_data;
  logic       Data_valid;

  joystick_reader #(
    .CLK_DIV    (CLK_DIV),
    .SS_DELAY   (SS_DELAY),
    .BYTE_GAP   (BYTE_GAP),
    .POLL_CYCLES(POLL_CYCLES),
    .LEFT_TH    (384),
    .RIGHT_TH   (640)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Led          (Led),
    .MISO         (MISO),
    .SS           (SS),
    .SCLK         (SCLK),
    .MOSI         (MOSI),
    .X_pos        (X_pos),
    .Y_pos        (Y_pos),
    .Joystick_data(Joystick_data),
    .Data_valid   (Data_valid)
  );

  // clock and cycle counter
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  // directed vectors: x, y, buttons, led, hand-computed Joystick_data
  int vx  [NVEC] = '{100, 900,  512, 384, 640, 385, 639, 641, 383, 0, 1023};
  int vy  [NVEC] = '{512,  37, 1023, 200, 640,   1,   2,   3,   4, 0, 1023};
  int vb  [NVEC] = '{  0,   2,    0,   0,   0,   0,   0,   0,   1, 4,    7};
  int vl  [NVEC] = '{  3,   1,    0,   2,   0,   0,   0,   0,   0, 0,    3};
  int vjd [NVEC] = '{  3,  15,    5,   5,   5,   5,   5,   7,  11, 3,   15};

  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          hold_viol = 0;
  logic [1:0]  cur_led;
  logic [39:0] stream;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur within bound", name);
  endtask

  // SPI slave model: mode 0, next bit presented after each SCLK fall
  int   sbit;
  logic s_pss, s_psc;
  initial begin
    MISO = 1'b0; s_pss = 1'b1; s_psc = 1'b0; sbit = 0;
    forever begin
      @(posedge Clk); #1;
      if (s_pss && !SS) begin
        sbit = 0;
        MISO = stream[39];
      end else if (!SS && s_psc && !SCLK) begin
        sbit++;
        MISO = (sbit < 40) ? stream[39 - sbit] : 1'b0;
      end
      s_pss = SS;
      s_psc = SCLK;
    end
  end

  // monitor: scoreboard pop on Data_valid, output hold, SS-window timing
  logic [23:0] m_e;
  logic [9:0]  hold_x, hold_y;
  logic [3:0]  hold_jd;
  logic        m_pdv, m_pss, m_psc, in_win;
  int          t_ss, t_rise, rises, first_dly, gap_err;
  logic [39:0] mcap;
  logic [7:0]  exp_cmd;
  initial begin
    m_pdv = 1'b0; m_pss = 1'b1; m_psc = 1'b0; in_win = 1'b0;
    hold_x = '0; hold_y = '0; hold_jd = 4'd5;
    t_ss = 0; t_rise = 0; rises = 0; first_dly = 0; gap_err = 0; mcap = '0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        in_win = 1'b0; m_pdv = 1'b0;
        hold_x = '0; hold_y = '0; hold_jd = 4'd5;
      end else begin
        if (m_pdv) check("dv_pulse_width", int'(Data_valid), 0);
        if (Data_valid) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_data_valid");
          end else begin
            m_e = exp_q.pop_front();
            check("x_pos", int'(X_pos), int'(m_e[23:14]));
            check("y_pos", int'(Y_pos), int'(m_e[13:4]));
            check("joystick_data", int'(Joystick_data), int'(m_e[3:0]));
            hold_x = m_e[23:14]; hold_y = m_e[13:4]; hold_jd = m_e[3:0];
          end
        end else if (X_pos !== hold_x || Y_pos !== hold_y || Joystick_data !== hold_jd) begin
          hold_viol++;
        end

        if (m_pss && !SS) begin
          in_win = 1'b1; t_ss = cyc; rises = 0; gap_err = 0; mcap = '0;
        end
        if (in_win && !m_psc && SCLK) begin
          if (rises == 0) first_dly = cyc - t_ss;
          else if ((rises % 8) != 0 && (cyc - t_rise) != 2 * CLK_DIV) gap_err++;
          t_rise = cyc;
          rises++;
          mcap = {mcap[38:0], MOSI};
        end
        if (in_win && !m_pss && SS) begin
          in_win  = 1'b0;
          exp_cmd = {6'b100000, cur_led};
          check("sclk_rises", rises, 40);
          check("ss_to_first_rise", first_dly, SS_DELAY + CLK_DIV);
          check("sclk_period_errors", gap_err, 0);
          check("mosi_cmd_byte", int'(mcap[39:32]), int'(exp_cmd));
          check("mosi_zero_bytes", int'(mcap[31:0]), 0);
        end
        m_pdv = Data_valid;
      end
      m_pss = SS;
      m_psc = SCLK;
    end
  end

  // driver tasks
  task automatic set_vec(input logic [9:0] x, input logic [9:0] y,
                         input logic [2:0] b, input logic [1:0] led);
    stream  = {x[7:0], 6'b101101, x[9:8], y[7:0], 6'b010110, y[9:8], 5'b10101, b};
    Led     = led;
    cur_led = led;
  endtask

  task automatic push_exp(input logic [9:0] x, input logic [9:0] y, input logic [3:0] jd);
    exp_q.push_back({x, y, jd});
  endtask

  task automatic wait_ss_fall(output int t);
    int n;
    n = 0;
    while (SS !== 1'b0 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    t = cyc;
    if (n >= 400) fail_now("ss_fall_timeout");
  endtask

  task automatic wait_dv();
    int n;
    n = 0;
    while (Data_valid !== 1'b1 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 400) fail_now("data_valid_timeout");
    @(negedge Clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ss"}, int'(SS), 1);
    check({tag, "_sclk"}, int'(SCLK), 0);
    check({tag, "_mosi"}, int'(MOSI), 0);
    check({tag, "_x_pos"}, int'(X_pos), 0);
    check({tag, "_y_pos"}, int'(Y_pos), 0);
    check({tag, "_joystick_data"}, int'(Joystick_data), 5);
    check({tag, "_data_valid"}, int'(Data_valid), 0);
  endtask

  int rel, t;
  initial begin
    Reset = 1'b0; Led = 2'b00; cur_led = 2'b00; stream = '0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");

    set_vec(10'(vx[0]), 10'(vy[0]), 3'(vb[0]), 2'(vl[0]));
    push_exp(10'(vx[0]), 10'(vy[0]), 4'(vjd[0]));
    Reset = 1'b1;
    rel = cyc;
    wait_ss_fall(t);
    check("first_start_latency", t - rel, POLL_CYCLES);
    wait_dv();

    for (int i = 1; i < NVEC; i++) begin
      set_vec(10'(vx[i]), 10'(vy[i]), 3'(vb[i]), 2'(vl[i]));
      push_exp(10'(vx[i]), 10'(vy[i]), 4'(vjd[i]));
      wait_dv();
    end

    // abort during byte 2: no update may appear
    set_vec(10'd800, 10'd900, 3'b011, 2'b01);
    wait_ss_fall(t);
    repeat (85) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(negedge Clk);
    set_vec(10'd700, 10'd300, 3'b000, 2'b10);
    push_exp(10'd700, 10'd300, 4'd7);
    Reset = 1'b1;
    rel = cyc;
    wait_ss_fall(t);
    check("restart_latency", t - rel, POLL_CYCLES);
    wait_dv();

    repeat (5) @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("output_hold_violations", hold_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/joystick_reader.md
JOYSTICK_READER -- requirements
Module: joystick_reader

Interface
REQ-001 Parameters SHALL be: CLK_DIV, default 50, Clk cycles per SCLK half-period; SS_DELAY, default 1500, Clk cycles from SS low to first SCLK edge; BYTE_GAP, default 1000, idle Clk cycles between bytes; POLL_CYCLES, default 1000000, transaction start period; LEFT_TH, default 384, X below this = left; RIGHT_TH, default 640, X above this = right.
REQ-002 Ports SHALL be, clock and reset first (name, direction, width, meaning):
- Clk, in, 1: system clock; one clock domain; all logic on rising edge.
- Reset, in, 1: asynchronous, active-low reset.
- Led, in, 2: PmodJSTK LED control, sent in command byte.
- MISO, in, 1: serial data from joystick.
- SS, out, 1: slave select, active-low.
- SCLK, out, 1: SPI clock, mode 0.
- MOSI, out, 1: serial data to joystick.
- X_pos, out, 10: last X reading.
- Y_pos, out, 10: last Y reading.
- Joystick_data, out, 4: Player control code.
- Data_valid, out, 1: one-cycle pulse on each update.

Function
REQ-003 Free-running poll counter SHALL count 0..POLL_CYCLES-1 and wrap; each wrap starts a transaction only in IDLE, and wraps outside IDLE are ignored.
REQ-004 FSM states SHALL be IDLE, SETUP, SHIFT, GAP, DONE.
REQ-005 IDLE->SETUP on poll wrap: SS driven 0 and SS_DELAY counter loaded.
REQ-006 SETUP->SHIFT after SS_DELAY cycles, with byte index 0 and bit index 7.
REQ-007 SHIFT SHALL generate 8 SCLK periods, each CLK_DIV low then CLK_DIV high.
REQ-008 SCLK SHALL idle low, and MOSI SHALL be valid from the start of each low phase, MSB first.
REQ-009 MISO SHALL be sampled into the shift register on the Clk edge where SCLK goes 0->1.
REQ-010 After the 8th high phase, SCLK SHALL return low and the byte SHALL be stored by index; bytes 0..3 go to GAP, byte 4 goes to DONE.
REQ-011 GAP SHALL hold SCLK low and SS low for BYTE_GAP cycles, then go to SHIFT with the next byte index.
REQ-012 MOSI bytes SHALL be: byte0 = {6'b100000, Led}; bytes 1..4 = 8'h00.
REQ-013 Received bytes SHALL map as: b0 = X[7:0]; b1[1:0] = X[9:8]; b2 = Y[7:0]; b3[1:0] = Y[9:8]; b4[2:0] = buttons; unused bits ignored.
REQ-014 DONE SHALL last 1 cycle: SS driven 1, X_pos/Y_pos/Joystick_data updated, Data_valid=1, then IDLE.
REQ-015 Joystick_data[2:0] SHALL be 3'd3 if X < LEFT_TH, 3'd7 if X > RIGHT_TH, else 3'd5; X == LEFT_TH or X == RIGHT_TH SHALL give 3'd5.
REQ-016 Joystick_data[3] (fire) SHALL equal b4[1] | b4[0].
REQ-017 Outputs SHALL change only in DONE; a partial transaction SHALL never update X_pos, Y_pos or Joystick_data.
REQ-018 Comparisons SHALL be unsigned 10-bit, and all counters SHALL be wide enough for their parameter without overflow.
REQ-019 POLL_CYCLES SHALL exceed SS_DELAY + 80*CLK_DIV + 4*BYTE_GAP + 2, or transactions are skipped per REQ-003.

Reset
REQ-020 Reset low SHALL immediately force: state IDLE, SS=1, SCLK=0, MOSI=0, X_pos=0, Y_pos=0, Joystick_data=4'd5, Data_valid=0, poll counter 0.
REQ-021 Reset mid-transaction SHALL abort it with no output update, and the first transaction SHALL start POLL_CYCLES cycles after Reset deasserts.

Verification (CLK_DIV=2, SS_DELAY=4, BYTE_GAP=3, POLL_CYCLES=200, LEFT_TH=384, RIGHT_TH=640)
REQ-022 Slave model returns X=100, Y=512, buttons=0 -> after DONE: X_pos=100, Y_pos=512, Joystick_data=4'd3, one Data_valid pulse.
REQ-023 Slave model returns X=900, buttons=3'b010 -> Joystick_data=4'd15; then X=512, buttons=0 on next poll -> Joystick_data=4'd5.
REQ-024 Slave model returns X=384, then X=640 -> Joystick_data=4'd5 both times; X=385..639 also gives 5; X=641 gives 7.
REQ-025 Led=2'b11 -> MOSI first byte 8'h83; exactly 40 SCLK rising edges per SS-low window; SCLK period 4 Clk cycles; SS low-to-first-rise delay of 4+2 cycles.
REQ-026 Reset asserted during byte 2 -> SS=1, SCLK=0 immediately, outputs hold their reset values; next transaction starts 200 cycles after release.
